// File: rtl/poly_th_bank.sv
// poly_th_bank: a bank of CH polymorphic NCL threshold gates with hysteresis.
// Each channel has one threshold for high supply mode and one for low supply mode.
// A mode change first drains the bank to NULL, then holds every output asleep
// for a settle interval, and only then switches the active mode.
module poly_th_bank #(
   parameter int unsigned CH         = 4,
   parameter int unsigned N          = 4,
   parameter int unsigned TW         = 3,
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vdd_sel_req,
   input  logic             s,
   input  logic [CH*N-1:0]  a,
   input  logic [CH*TW-1:0] thr_hi,
   input  logic [CH*TW-1:0] thr_lo,
   output logic [CH-1:0]    z,
   output logic             vdd_sel_cur,
   output logic             busy,
   output logic             mode_ack
);

   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tgt_q, tgt_d;
   logic          vdd_sel_cur_q, vdd_sel_cur_d;
   logic          busy_q, busy_d;
   logic          mode_ack_q, mode_ack_d;
   logic [CH-1:0] z_q, z_d;
   logic          sleep_int;

   assign sleep_int = (state_q != ST_RUN);

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [TW-1:0] pop_c;
      logic [TW-1:0] thr_c;
      logic          z_nxt;

      // Count of asserted inputs on this channel; all inputs carry weight 1.
      always_comb begin
         pop_c = '0;
         for (int i = 0; i < int'(N); i++) begin
            pop_c = pop_c + TW'(a[c*N + i]);
         end
      end

      assign thr_c = vdd_sel_cur_q ? thr_hi[c*TW +: TW] : thr_lo[c*TW +: TW];

      // Threshold gate with hysteresis. A threshold above N can never be reached.
      always_comb begin
         z_nxt = z_q[c];
         if (s || sleep_int) begin
            z_nxt = 1'b0;
         end else if (thr_c == '0) begin
            z_nxt = 1'b0;
         end else if (pop_c >= thr_c) begin
            z_nxt = 1'b1;
         end else if (pop_c == '0) begin
            z_nxt = 1'b0;
         end
      end

      assign z_d[c] = z_nxt;
   end

   // Mode-switch sequencer. The target mode is latched on entry to DRAIN.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tgt_d         = tgt_q;
      vdd_sel_cur_d = vdd_sel_cur_q;
      mode_ack_d    = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (vdd_sel_req != vdd_sel_cur_q) begin
               tgt_d   = vdd_sel_req;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((a == '0) && (z_q == '0)) begin
               cnt_d   = CW'(SETTLE_CYC - 1);
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               vdd_sel_cur_d = tgt_q;
               mode_ack_d    = 1'b1;
               state_d       = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      busy_d = (state_d != ST_RUN);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         cnt_q         <= '0;
         tgt_q         <= 1'b0;
         vdd_sel_cur_q <= 1'b0;
         busy_q        <= 1'b0;
         mode_ack_q    <= 1'b0;
         z_q           <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tgt_q         <= tgt_d;
         vdd_sel_cur_q <= vdd_sel_cur_d;
         busy_q        <= busy_d;
         mode_ack_q    <= mode_ack_d;
         z_q           <= z_d;
      end
   end

   assign z           = z_q;
   assign vdd_sel_cur = vdd_sel_cur_q;
   assign busy        = busy_q;
   assign mode_ack    = mode_ack_q;

endmodule

// File: tb/tb_poly_th_bank.sv
// Directed self-checking bench for poly_th_bank (CH=4, N=4, TW=3, SETTLE_CYC=4).
module tb_poly_th_bank;

   localparam int unsigned CH = 4;
   localparam int unsigned N  = 4;
   localparam int unsigned TW = 3;

   logic             clk;
   logic             rst_n;
   logic             vdd_sel_req;
   logic             s;
   logic [CH*N-1:0]  a;
   logic [CH*TW-1:0] thr_hi;
   logic [CH*TW-1:0] thr_lo;
   logic [CH-1:0]    z;
   logic             vdd_sel_cur;
   logic             busy;
   logic             mode_ack;

   int n_assert;
   int n_fail;

   poly_th_bank #(.CH(4), .N(4), .TW(3), .SETTLE_CYC(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vdd_sel_req (vdd_sel_req),
      .s           (s),
      .a           (a),
      .thr_hi      (thr_hi),
      .thr_lo      (thr_lo),
      .z           (z),
      .vdd_sel_cur (vdd_sel_cur),
      .busy        (busy),
      .mode_ack    (mode_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      vdd_sel_req = 1'b0;
      s           = 1'b0;
      a           = '0;
      // channel 3..0 : low {2,5,0,3}, high {1,1,1,1}
      thr_lo      = {3'd2, 3'd5, 3'd0, 3'd3};
      thr_hi      = {3'd1, 3'd1, 3'd1, 3'd1};
      #12;
      chk("rst_z",    32'(z),           32'h0);
      chk("rst_vdd",  32'(vdd_sel_cur), 32'h0);
      chk("rst_busy", 32'(busy),        32'h0);
      chk("rst_ack",  32'(mode_ack),    32'h0);
      rst_n = 1'b1;

      // Basic threshold with hysteresis in low mode, thr_lo0 = 3
      a = 16'h0007; step();
      chk("ch0_set",  32'(z), 32'h1);
      a = 16'h0001; step();
      chk("ch0_hold", 32'(z), 32'h1);
      a = 16'h0000; step();
      chk("ch0_null", 32'(z), 32'h0);

      // ch1 disabled (thr 0), ch2 thr 5 > N, ch3 thr 2 with 2 inputs set
      a = 16'h3FF0; step();
      chk("dis_a", 32'(z), 32'h8);
      step();
      chk("dis_b", 32'(z), 32'h8);

      // Low -> high switch with NULL inputs
      a = '0; step();
      chk("null_z", 32'(z), 32'h0);
      vdd_sel_req = 1'b1;
      step();
      chk("sw1_busy", 32'(busy), 32'h1);
      chk("sw1_ack0", 32'(mode_ack), 32'h0);
      for (int k = 2; k <= 6; k++) begin
         step();
         if (k < 6) begin
            chk("sw1_wait_ack", 32'(mode_ack), 32'h0);
            chk("sw1_wait_vdd", 32'(vdd_sel_cur), 32'h0);
         end else begin
            chk("sw1_ack",  32'(mode_ack),    32'h1);
            chk("sw1_vdd",  32'(vdd_sel_cur), 32'h1);
            chk("sw1_busy0", 32'(busy),       32'h0);
         end
      end
      step();
      chk("sw1_ack_pulse", 32'(mode_ack), 32'h0);
      a = 16'h0001; step();
      chk("hi_thr1", 32'(z), 32'h1);

      // Switch request while inputs are not NULL: DRAIN holds
      a = 16'h0003; step();
      chk("hi_z0", 32'(z), 32'h1);
      vdd_sel_req = 1'b0;
      step();
      chk("dr_busy", 32'(busy), 32'h1);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("dr_z",    32'(z),           32'h0);
         chk("dr_busy", 32'(busy),        32'h1);
         chk("dr_ack",  32'(mode_ack),    32'h0);
         chk("dr_vdd",  32'(vdd_sel_cur), 32'h1);
      end
      a = '0; step();
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k < 4) begin
            chk("dr_settle_ack", 32'(mode_ack), 32'h0);
         end else begin
            chk("dr_ack1", 32'(mode_ack),    32'h1);
            chk("dr_vdd0", 32'(vdd_sel_cur), 32'h0);
         end
      end
      step();
      chk("dr_ack_pulse", 32'(mode_ack), 32'h0);

      // Request toggled back inside SETTLE: two full sequences
      vdd_sel_req = 1'b1;
      step();
      step();
      vdd_sel_req = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k < 4) begin
            chk("tg_ack_a", 32'(mode_ack), 32'h0);
         end else begin
            chk("tg_ack1", 32'(mode_ack),    32'h1);
            chk("tg_vdd1", 32'(vdd_sel_cur), 32'h1);
         end
      end
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k == 1) chk("tg_busy2", 32'(busy), 32'h1);
         if (k < 6) begin
            chk("tg_ack_b", 32'(mode_ack), 32'h0);
         end else begin
            chk("tg_ack2", 32'(mode_ack),    32'h1);
            chk("tg_vdd2", 32'(vdd_sel_cur), 32'h0);
         end
      end
      step();

      // Reset in the middle of a high -> low SETTLE
      vdd_sel_req = 1'b1;
      for (int k = 1; k <= 6; k++) step();
      chk("rs_pre_vdd", 32'(vdd_sel_cur), 32'h1);
      vdd_sel_req = 1'b0;
      step();
      step();
      step();
      chk("rs_mid_busy", 32'(busy),        32'h1);
      chk("rs_mid_vdd",  32'(vdd_sel_cur), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rs_z",    32'(z),           32'h0);
      chk("rs_busy", 32'(busy),        32'h0);
      chk("rs_ack",  32'(mode_ack),    32'h0);
      chk("rs_vdd",  32'(vdd_sel_cur), 32'h0);
      rst_n = 1'b1;
      step();
      chk("rs_run_busy_a", 32'(busy), 32'h0);
      step();
      chk("rs_run_busy_b", 32'(busy), 32'h0);
      chk("rs_run_ack",    32'(mode_ack), 32'h0);

      // External sleep in RUN
      thr_lo = {3'd1, 3'd1, 3'd1, 3'd1};
      a      = 16'hFFFF;
      step();
      chk("sl_pre_z", 32'(z), 32'hF);
      s = 1'b1;
      step();
      chk("sl_z_a",    32'(z),    32'h0);
      chk("sl_busy_a", 32'(busy), 32'h0);
      step();
      chk("sl_z_b",    32'(z),    32'h0);
      chk("sl_busy_b", 32'(busy), 32'h0);
      s = 1'b0;
      step();
      chk("sl_post_z", 32'(z), 32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
